// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one ready/ack bus transaction per load or store,
// with pipeline stall, alignment/funct3 fault detection and a bus timeout.
module mem_stage_lsu #(
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  MemWriteM,
   input  logic [1:0]            ResultSrcM,
   input  logic [2:0]            Funct3M,
   input  logic [DATA_WIDTH-1:0] ALUResultM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   output logic                  StallM,
   output logic [DATA_WIDTH-1:0] ReadDataM,
   output logic                  AccessFaultM,
   output logic                  BusErrM,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wstrb,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_f3;
   logic [1:0]      r_off;

   logic                  w_access;
   logic                  w_misalign;
   logic                  w_bad_f3;
   logic                  w_fault;
   logic [3:0]            w_wstrb;
   logic [DATA_WIDTH-1:0] w_wdata;

   // Select the addressed lane and sign/zero-extend according to the access size.
   function automatic logic [DATA_WIDTH-1:0] f_extract(
      input logic [2:0]            f3,
      input logic [1:0]            off,
      input logic [DATA_WIDTH-1:0] rd
   );
      logic [DATA_WIDTH-1:0] sh;
      sh = rd >> {off, 3'b000};
      case (f3)
         3'b000:  f_extract = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
         3'b001:  f_extract = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
         3'b010:  f_extract = rd;
         3'b100:  f_extract = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
         3'b101:  f_extract = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
         default: f_extract = {DATA_WIDTH{1'b0}};
      endcase
   endfunction

   // Decode access kind, fault condition and store lane strobes/data.
   always_comb begin
      w_access   = MemWriteM | (ResultSrcM == 2'b01);
      w_misalign = 1'b0;
      w_bad_f3   = 1'b0;
      w_wstrb    = 4'b0000;
      w_wdata    = WriteDataM;
      case (Funct3M)
         3'b000: begin
            w_wstrb = 4'b0001 << ALUResultM[1:0];
            w_wdata = DATA_WIDTH'({4{WriteDataM[7:0]}});
         end
         3'b001: begin
            w_misalign = ALUResultM[0];
            w_wstrb    = 4'b0011 << ALUResultM[1:0];
            w_wdata    = DATA_WIDTH'({2{WriteDataM[15:0]}});
         end
         3'b010: begin
            w_misalign = |ALUResultM[1:0];
            w_wstrb    = 4'b1111;
         end
         3'b100: begin
            w_bad_f3 = MemWriteM;
         end
         3'b101: begin
            w_misalign = ALUResultM[0];
            w_bad_f3   = MemWriteM;
         end
         default: begin
            w_bad_f3 = 1'b1;
         end
      endcase
      w_fault = w_misalign | w_bad_f3;
   end

   // Stall is combinational in IDLE so the issuing instruction is held on its first cycle.
   assign StallM = rst_n & ((r_state == S_REQ) |
                            ((r_state == S_IDLE) & w_access & ~w_fault));

   // Transaction FSM with registered bus and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= {CW{1'b0}};
         r_f3         <= 3'b000;
         r_off        <= 2'b00;
         ReadDataM    <= {DATA_WIDTH{1'b0}};
         AccessFaultM <= 1'b0;
         BusErrM      <= 1'b0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= {DATA_WIDTH{1'b0}};
         mem_wdata    <= {DATA_WIDTH{1'b0}};
         mem_wstrb    <= 4'b0000;
      end else begin
         AccessFaultM <= 1'b0;
         BusErrM      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_access & w_fault) begin
                  AccessFaultM <= 1'b1;
                  ReadDataM    <= {DATA_WIDTH{1'b0}};
               end else if (w_access) begin
                  mem_req   <= 1'b1;
                  mem_we    <= MemWriteM;
                  mem_addr  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
                  mem_wstrb <= MemWriteM ? w_wstrb : 4'b0000;
                  mem_wdata <= MemWriteM ? w_wdata : {DATA_WIDTH{1'b0}};
                  r_f3      <= Funct3M;
                  r_off     <= ALUResultM[1:0];
                  r_cnt     <= {CW{1'b0}};
                  r_state   <= S_REQ;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_REQ: begin
               if (mem_ack) begin
                  if (!mem_we) begin
                     ReadDataM <= f_extract(r_f3, r_off, mem_rdata);
                  end else begin
                     ReadDataM <= ReadDataM;
                  end
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= {DATA_WIDTH{1'b0}};
                  mem_wdata <= {DATA_WIDTH{1'b0}};
                  mem_wstrb <= 4'b0000;
                  r_state   <= S_DONE;
               end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                  ReadDataM <= {DATA_WIDTH{1'b0}};
                  BusErrM   <= 1'b1;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= {DATA_WIDTH{1'b0}};
                  mem_wdata <= {DATA_WIDTH{1'b0}};
                  mem_wstrb <= 4'b0000;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a small bus responder answers requests after a
// chosen number of wait cycles; results are checked against hand-computed values.
module tb_mem_stage_lsu;

   logic        clk;
   logic        rst_n;
   logic        MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic        StallM;
   logic [31:0] ReadDataM;
   logic        AccessFaultM;
   logic        BusErrM;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int n_vec = 0;
   int n_err = 0;

   int          stall_n;
   int          req_n;
   logic        stable;
   logic        done;
   logic        cap_we;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [3:0]  cap_wstrb;

   mem_stage_lsu #(.DATA_WIDTH(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .StallM(StallM), .ReadDataM(ReadDataM),
      .AccessFaultM(AccessFaultM), .BusErrM(BusErrM),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bubble();
      MemWriteM  = 1'b0;
      ResultSrcM = 2'b00;
      Funct3M    = 3'b000;
      ALUResultM = 32'h0;
      WriteDataM = 32'h0;
   endtask

   // Present an instruction at a negedge and act as the bus until StallM drops.
   // Returns at the negedge of the first non-stalled cycle (DONE for real transfers).
   task automatic run(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input int ack_wait, input logic [31:0] rd);
      MemWriteM = we; ResultSrcM = rs; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
      stall_n = 0; req_n = 0; stable = 1'b1; done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (!StallM) begin
            done = 1'b1;
            break;
         end
         stall_n++;
         if (mem_req) begin
            if (req_n == 0) begin
               cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata; cap_wstrb = mem_wstrb;
            end else if (mem_we !== cap_we || mem_addr !== cap_addr ||
                         mem_wdata !== cap_wdata || mem_wstrb !== cap_wstrb) begin
               stable = 1'b0;
            end
            mem_ack = (req_n == ack_wait);
            req_n++;
         end else begin
            mem_ack = 1'b0;
         end
         mem_rdata = rd;
         @(negedge clk);
      end
      mem_ack = 1'b0;
      bubble();
   endtask

   initial begin
      rst_n = 1'b0;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      bubble();
      @(negedge clk);
      chk("rst_req", {31'b0, mem_req}, 32'd0);
      chk("rst_stall", {31'b0, StallM}, 32'd0);
      chk("rst_rdata", ReadDataM, 32'h0);
      chk("rst_flags", {30'b0, AccessFaultM, BusErrM}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // LW 0x100, immediate ack
      run(1'b0, 2'b01, 3'b010, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
      chk("lw_done", {31'b0, done}, 32'd1);
      chk("lw_stall", stall_n, 32'd2);
      chk("lw_addr", cap_addr, 32'h0000_0100);
      chk("lw_we", {31'b0, cap_we}, 32'd0);
      chk("lw_strb", {28'b0, cap_wstrb}, 32'd0);
      chk("lw_rdata", ReadDataM, 32'hDEAD_BEEF);
      chk("lw_req_done", {31'b0, mem_req}, 32'd0);
      @(negedge clk);

      // LB / LBU at 0x103
      run(1'b0, 2'b01, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h8011_2233);
      chk("lb_stall", stall_n, 32'd2);
      chk("lb_addr", cap_addr, 32'h0000_0100);
      chk("lb_rdata", ReadDataM, 32'hFFFF_FF80);
      @(negedge clk);
      run(1'b0, 2'b01, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h8011_2233);
      chk("lbu_rdata", ReadDataM, 32'h0000_0080);
      @(negedge clk);

      // SH 0x102 with three ack wait cycles
      run(1'b1, 2'b00, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 3, 32'h1234_5678);
      chk("sh_stall", stall_n, 32'd5);
      chk("sh_strb", {28'b0, cap_wstrb}, 32'h0000_000C);
      chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
      chk("sh_we", {31'b0, cap_we}, 32'd1);
      chk("sh_addr", cap_addr, 32'h0000_0100);
      chk("sh_stable", {31'b0, stable}, 32'd1);
      chk("sh_rdata_kept", ReadDataM, 32'h0000_0080);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("sh_no_reissue", {30'b0, mem_req, StallM}, 32'd0);
      end

      // LH 0x102 upper half, sign-extended
      run(1'b0, 2'b01, 3'b001, 32'h0000_0102, 32'h0, 1, 32'h8011_2233);
      chk("lh_stall", stall_n, 32'd3);
      chk("lh_rdata", ReadDataM, 32'hFFFF_8011);
      @(negedge clk);

      // ack while idle is ignored
      mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
      @(negedge clk);
      @(negedge clk);
      chk("idle_ack_rdata", ReadDataM, 32'hFFFF_8011);
      chk("idle_ack_req", {30'b0, mem_req, StallM}, 32'd0);
      mem_ack = 1'b0;

      // SB 0x101
      run(1'b1, 2'b00, 3'b000, 32'h0000_0101, 32'h0000_005A, 0, 32'h0);
      chk("sb_strb", {28'b0, cap_wstrb}, 32'h0000_0002);
      chk("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
      chk("sb_rdata_kept", ReadDataM, 32'hFFFF_8011);
      @(negedge clk);

      // SW with no ack: timeout
      run(1'b1, 2'b00, 3'b010, 32'h0000_0200, 32'h1234_5678, 99, 32'h0);
      chk("to_done", {31'b0, done}, 32'd1);
      chk("to_req_cycles", req_n, 32'd16);
      chk("to_stall", stall_n, 32'd17);
      chk("to_buserr", {31'b0, BusErrM}, 32'd1);
      chk("to_rdata", ReadDataM, 32'h0);
      chk("to_req_low", {31'b0, mem_req}, 32'd0);
      @(negedge clk);
      chk("to_buserr_pulse", {31'b0, BusErrM}, 32'd0);

      // LW 0x101: misaligned fault
      MemWriteM = 1'b0; ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h0000_0101;
      #1;
      chk("flt_stall", {31'b0, StallM}, 32'd0);
      @(negedge clk);
      bubble();
      chk("flt_pulse", {31'b0, AccessFaultM}, 32'd1);
      chk("flt_req", {31'b0, mem_req}, 32'd0);
      @(negedge clk);
      chk("flt_pulse_end", {30'b0, AccessFaultM, mem_req}, 32'd0);

      // Store with a load-only funct3 (SBU) is illegal
      MemWriteM = 1'b1; ResultSrcM = 2'b00; Funct3M = 3'b100; ALUResultM = 32'h0000_0010;
      #1;
      chk("ilf_stall", {31'b0, StallM}, 32'd0);
      @(negedge clk);
      bubble();
      chk("ilf_pulse", {30'b0, AccessFaultM, mem_req}, 32'd2);
      @(negedge clk);

      // Reset while in REQ
      MemWriteM = 1'b0; ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h0000_0300;
      @(negedge clk);
      chk("mid_req_active", {31'b0, mem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_req", {31'b0, mem_req}, 32'd0);
      chk("mid_rst_stall", {31'b0, StallM}, 32'd0);
      chk("mid_rst_addr", mem_addr, 32'h0);
      bubble();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", {30'b0, mem_req, StallM}, 32'd0);
      run(1'b0, 2'b01, 3'b101, 32'h0000_0302, 32'h0, 1, 32'h9876_0055);
      chk("post_rst_stall", stall_n, 32'd3);
      chk("post_rst_lhu", ReadDataM, 32'h0000_9876);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
